// File: rtl/systolic_skew_feeder.sv
// Latches a 3x3 operand matrix on start and feeds row-skewed, zero-padded streams to a systolic array.
// Optional macro FEEDER_REVERSE_EN emits each row in reverse column order for arrays with mirrored weights.
module systolic_skew_feeder #(
  parameter int W     = 8,
  parameter int DRAIN = 6
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic [W-1:0] A11_i,
  input  logic [W-1:0] A12_i,
  input  logic [W-1:0] A13_i,
  input  logic [W-1:0] A21_i,
  input  logic [W-1:0] A22_i,
  input  logic [W-1:0] A23_i,
  input  logic [W-1:0] A31_i,
  input  logic [W-1:0] A32_i,
  input  logic [W-1:0] A33_i,
  output logic [W-1:0] left1_o,
  output logic [W-1:0] left2_o,
  output logic [W-1:0] left3_o,
  output logic         busy_o,
  output logic         done_o,
  output logic [3:0]   cycle_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FEED,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [3:0] FEED_LAST  = 4'd4;
  localparam logic [3:0] DRAIN_LAST = 4'(4 + DRAIN);

  // Column visited first / last within a row stream.
`ifdef FEEDER_REVERSE_EN
  localparam int C_FIRST = 2;
  localparam int C_LAST  = 0;
`else
  localparam int C_FIRST = 0;
  localparam int C_LAST  = 2;
`endif
  localparam int C_MID = 1;

  state_t       state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         accept;

  logic [W-1:0] a_in  [9];
  logic [W-1:0] mat_q [9];
  logic [W-1:0] mat_d [9];

  logic [W-1:0] left1_q, left1_d;
  logic [W-1:0] left2_q, left2_d;
  logic [W-1:0] left3_q, left3_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic [3:0]   cycle_q, cycle_d;

  assign a_in[0] = A11_i;
  assign a_in[1] = A12_i;
  assign a_in[2] = A13_i;
  assign a_in[3] = A21_i;
  assign a_in[4] = A22_i;
  assign a_in[5] = A23_i;
  assign a_in[6] = A31_i;
  assign a_in[7] = A32_i;
  assign a_in[8] = A33_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          accept  = 1'b1;
          state_d = S_FEED;
          cnt_d   = 4'd0;
        end
      end
      S_FEED: begin
        if (cnt_q == FEED_LAST) begin
          state_d = S_DRAIN;
        end
        cnt_d = cnt_q + 4'd1;
      end
      S_DRAIN: begin
        if (cnt_q == DRAIN_LAST) begin
          state_d = S_DONE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_DONE: begin
        cnt_d = 4'd0;
        if (start_i) begin
          accept  = 1'b1;
          state_d = S_FEED;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Forward the freshly accepted matrix so t0 is registered on the accepting edge.
  always_comb begin
    for (int k = 0; k < 9; k++) begin
      mat_d[k] = accept ? a_in[k] : mat_q[k];
    end
  end

  always_comb begin
    left1_d = '0;
    left2_d = '0;
    left3_d = '0;
    if (state_d == S_FEED) begin
      case (cnt_d)
        4'd0: begin
          left1_d = mat_d[C_FIRST];
        end
        4'd1: begin
          left1_d = mat_d[C_MID];
          left2_d = mat_d[3 + C_FIRST];
        end
        4'd2: begin
          left1_d = mat_d[C_LAST];
          left2_d = mat_d[3 + C_MID];
          left3_d = mat_d[6 + C_FIRST];
        end
        4'd3: begin
          left2_d = mat_d[3 + C_LAST];
          left3_d = mat_d[6 + C_MID];
        end
        4'd4: begin
          left3_d = mat_d[6 + C_LAST];
        end
        default: begin
          left1_d = '0;
        end
      endcase
    end
  end

  always_comb begin
    busy_d  = (state_d == S_FEED) || (state_d == S_DRAIN);
    done_d  = (state_d == S_DONE);
    cycle_d = busy_d ? cnt_d : 4'd0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      mat_q   <= '{default: '0};
      left1_q <= '0;
      left2_q <= '0;
      left3_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cycle_q <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mat_q   <= mat_d;
      left1_q <= left1_d;
      left2_q <= left2_d;
      left3_q <= left3_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cycle_q <= cycle_d;
    end
  end

  assign left1_o = left1_q;
  assign left2_o = left2_q;
  assign left3_o = left3_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign cycle_o = cycle_q;

endmodule
